pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Program-counter register and instruction-fetch sequencer, directly upstream of JUMP_Mux.
//  Supplies pc_plus4 to the jump mux Pc_in input, takes the mux output back as next_pc, and
//  issues one instruction-memory request per PC. Presents each fetched word to decode over a
//  valid/ready handshake. Supports stall, flush/redirect and fetch timeout.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC loaded on reset
//  TIMEOUT     16             cycles to wait for imem_ack before flagging fetch_err and re-issuing
// PORTS
//  clk          in   1   system clock, all state on rising edge
//  rst          in   1   synchronous, active-high reset
//  next_pc      in   32  next PC from jump mux (pc_plus4 or jump target)
//  stall        in   1   hazard unit: hold PC and instruction, issue no new request
//  flush        in   1   control transfer resolved: drop current instruction, load next_pc
//  imem_req     out  1   instruction memory request (level)
//  imem_addr    out  32  request address = pc
//  imem_ack     in   1   memory response valid, may arrive in same cycle as imem_req
//  imem_rdata   in   32  instruction word, sampled when imem_ack=1
//  pc_out       out  32  PC of instruction held in instr_out
//  pc_plus4     out  32  pc + 32'd4 (combinational, wraps modulo 2^32) -> jump mux Pc_in
//  instr_out    out  32  fetched instruction
//  instr_valid  out  1   instr_out/pc_out valid
//  instr_ready  in   1   decode accepts instruction
//  fetch_err    out  1   one-cycle pulse on timeout
//  align_err    out  1   sticky misaligned-target flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst=1 at edge): pc=RESET_PC, state=S_IDLE, imem_req=0, instr_valid=0, instr_out=32'h0,
//   fetch_err=0, align_err=0, drop=0, timeout counter=0. Reset wins over all other inputs in all states.
//  States: S_IDLE -> S_REQ (unconditional, 1 cycle after reset release).
//   S_REQ: imem_req=1, imem_addr=pc, held stable until ack. On ack & !drop: instr_out<=imem_rdata,
//    pc_out<=pc, instr_valid<=1 -> S_VALID. On ack & drop: discard word, clear drop, pc<=next_pc, stay S_REQ.
//   S_VALID: imem_req=0. If instr_ready & !stall: instr_valid<=0, pc<=next_pc -> S_REQ.
//  Latency: request in the cycle after PC load; zero-wait ack gives instr_valid one cycle after req.
//  Handshake: transfer only when instr_valid & instr_ready & !stall; stall dominates ready.
//  stall in S_REQ: outstanding request still completes and is captured; no new PC load.
//  flush (priority over stall): S_VALID -> instr_valid<=0, pc<=next_pc, S_REQ.
//   S_REQ without ack: set drop, keep imem_req (an issued request is never withdrawn).
//   S_REQ with ack in same cycle: word discarded, pc<=next_pc, S_REQ.
//  Timeout: counter increments each S_REQ cycle without ack, clears on ack or state exit.
//   At TIMEOUT-1 with no ack: fetch_err pulses 1 cycle; counter clears, request re-issued (same pc).
//  next_pc is sampled only at PC-load edges; it is unused in all other cycles.
// CONFIGURATION
//  FETCH_ALIGN_CHECK_EN defined: on each PC load, if next_pc[1:0]!=2'b00, align_err<=1 (sticky
//   until rst) and pc<={next_pc[31:2],2'b00}.
//  Not defined: next_pc loaded verbatim, align_err tied 0. Port list identical in both builds.
// STRUCTURE
//  fetch_pkg: state enum (S_IDLE,S_REQ,S_VALID, 2-bit), PC_INCR=32'd4, default RESET_PC.
//  One sub-module: fetch_timeout_ctr (clear, enable, expire pulse; width $clog2(TIMEOUT)).
//  PC register, FSM, drop flag and instruction register stay in pc_fetch_unit.
// TESTING
//  1 Reset, ack always 1, ready=1, next_pc=pc_plus4 -> imem_addr 0,4,8,C; instr_valid pulses one
//    cycle after each req.
//  2 In S_VALID for pc=0x10, drive next_pc=0x400 with ready=1 -> next imem_addr=0x400,
//    pc_out=0x400 with the new word.
//  3 ready=0 for 5 cycles with instr_valid=1 -> instr_out, pc_out stable, imem_req=0; then accept.
//  4 Assert flush while req for 0x20 is pending (ack 3 cycles later), next_pc=0x100 -> word for
//    0x20 never valid; next request is addr 0x100.
//  5 ack withheld, TIMEOUT=16 -> fetch_err high exactly on 16th req cycle; req stays high with addr
//    unchanged; later ack captured normally.
//  6 With FETCH_ALIGN_CHECK_EN, next_pc=0x203 -> imem_addr=0x200, align_err=1 until rst;
//    without macro -> imem_addr=0x203, align_err=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the PC/fetch sequencer: FSM encoding, PC increment,
// default reset vector and a word-alignment helper.
package fetch_pkg;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t S_IDLE  = 2'd0;
    localparam fetch_state_t S_REQ   = 2'd1;
    localparam fetch_state_t S_VALID = 2'd2;

    localparam logic [31:0] PC_INCR          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Counts cycles spent waiting for an instruction-memory ack; expire_o is a combinational
// one-cycle pulse on the TIMEOUT-th consecutive enabled cycle, after which the count restarts.
module fetch_timeout_ctr #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expire_o = enable_i && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || expire_o) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer feeding decode over valid/ready.
// Optional build macro FETCH_ALIGN_CHECK_EN: force word-aligned PC loads and flag misaligned targets.
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_pc,
    input  logic        stall,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        fetch_err,
    output logic        align_err
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pc_out_q, pc_out_d;
    logic [31:0]  instr_q, instr_d;
    logic         valid_q, valid_d;
    logic         drop_q, drop_d;
    logic         load_pc;
    logic [31:0]  load_val;
    logic         tmo_clear;
    logic         tmo_enable;

    assign imem_req    = (state_q == S_REQ);
    assign imem_addr   = pc_q;
    assign pc_plus4    = pc_q + PC_INCR;
    assign pc_out      = pc_out_q;
    assign instr_out   = instr_q;
    assign instr_valid = valid_q;

    // The counter only runs while a request is outstanding and unanswered.
    assign tmo_enable = (state_q == S_REQ) && !imem_ack;
    assign tmo_clear  = (state_q != S_REQ) || imem_ack;

    fetch_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (tmo_clear),
        .enable_i (tmo_enable),
        .expire_o (fetch_err)
    );

`ifdef FETCH_ALIGN_CHECK_EN
    logic align_err_q, align_err_d;

    assign load_val  = word_align(next_pc);
    assign align_err = align_err_q;

    always_comb begin
        align_err_d = align_err_q;
        if (load_pc && (next_pc[1:0] != 2'b00)) begin
            align_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            align_err_q <= 1'b0;
        end else begin
            align_err_q <= align_err_d;
        end
    end
`else
    assign load_val  = next_pc;
    assign align_err = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        pc_out_d = pc_out_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        drop_d   = drop_q;
        load_pc  = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                // An issued request is never withdrawn; a flush only marks its word for discard.
                if (imem_ack) begin
                    if (drop_q || flush) begin
                        drop_d  = 1'b0;
                        load_pc = 1'b1;
                    end else begin
                        instr_d  = imem_rdata;
                        pc_out_d = pc_q;
                        valid_d  = 1'b1;
                        state_d  = S_VALID;
                    end
                end else if (flush) begin
                    drop_d = 1'b1;
                end
            end
            S_VALID: begin
                if (flush || (instr_ready && !stall)) begin
                    valid_d = 1'b0;
                    load_pc = 1'b1;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        pc_d = load_pc ? load_val : pc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            pc_out_q <= RESET_PC;
            instr_q  <= 32'h0;
            valid_q  <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_out_q <= pc_out_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            drop_q   <= drop_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios followed by random traffic,
// all checked cycle by cycle against a behavioural model of the fetch rules.
module tb_pc_fetch_unit;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] next_pc = 32'h0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        fetch_err;
    logic        align_err;

    pc_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .next_pc     (next_pc),
        .stall       (stall),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .pc_out      (pc_out),
        .pc_plus4    (pc_plus4),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .fetch_err   (fetch_err),
        .align_err   (align_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase 0 = just out of reset, 1 = request outstanding, 2 = word held for decode
    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_pc_out;
    logic [31:0] m_instr;
    logic        m_drop;
    logic        m_align;
    int          m_wait;

    logic        last_ferr;
    logic [31:0] req_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] np);
`ifdef FETCH_ALIGN_CHECK_EN
        if (np[1:0] != 2'b00) m_align = 1'b1;
        return {np[31:2], 2'b00};
`else
        return np;
`endif
    endfunction

    task automatic model_reset();
        m_phase  = 0;
        m_pc     = 32'h0;
        m_pc_out = 32'h0;
        m_instr  = 32'h0;
        m_drop   = 1'b0;
        m_align  = 1'b0;
        m_wait   = 0;
    endtask

    // One clock: drive inputs just after a falling edge, check, advance the model, wait for next falling edge.
    task automatic cyc(input logic ack, input logic [31:0] rd, input logic fl, input logic st,
                       input logic rdy, input logic [31:0] np);
        imem_ack    = ack;
        imem_rdata  = rd;
        flush       = fl;
        stall       = st;
        instr_ready = rdy;
        next_pc     = np;
        #1;
        chk("imem_req", 32'(imem_req), 32'(m_phase == 1));
        if (m_phase == 1) chk("imem_addr", imem_addr, m_pc);
        chk("instr_valid", 32'(instr_valid), 32'(m_phase == 2));
        if (m_phase == 2) chk("pc_out", pc_out, m_pc_out);
        chk("instr_out", instr_out, m_instr);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("fetch_err", 32'(fetch_err), 32'(m_phase == 1 && !ack && m_wait == TIMEOUT - 1));
        chk("align_err", 32'(align_err), 32'(m_align));
        last_ferr = fetch_err;
        if (imem_req) req_log.push_back(imem_addr);

        if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (ack) begin
                m_wait = 0;
                if (m_drop || fl) begin
                    m_drop = 1'b0;
                    m_pc   = model_load(np);
                end else begin
                    m_instr  = rd;
                    m_pc_out = m_pc;
                    m_phase  = 2;
                end
            end else begin
                if (fl) m_drop = 1'b1;
                m_wait = (m_wait == TIMEOUT - 1) ? 0 : m_wait + 1;
            end
        end else begin
            if (fl || (rdy && !st)) begin
                m_pc    = model_load(np);
                m_phase = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_ack = 1'b0;
        flush = 1'b0;
        stall = 1'b0;
        instr_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        chk("rst_imem_req", 32'(imem_req), 32'h0);
        chk("rst_instr_valid", 32'(instr_valid), 32'h0);
        chk("rst_instr_out", instr_out, 32'h0);
        chk("rst_fetch_err", 32'(fetch_err), 32'h0);
        chk("rst_align_err", 32'(align_err), 32'h0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        req_log.delete();
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] exp_addr;
        logic [31:0] np;
        logic        ack, fl, st, rdy;
        int          ack_pct;

        @(negedge clk);
        do_reset();

        // Sequential fetch with zero-wait memory
        for (int i = 0; i < 8; i++) cyc(1'b1, $urandom, 1'b0, 1'b0, 1'b1, m_pc + 32'd4);
        chk("t1_req_count", 32'(req_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < req_log.size(); i++) chk("t1_req_addr", req_log[i], 32'(i * 4));
        cyc(1'b1, $urandom, 1'b0, 1'b0, 1'b1, m_pc + 32'd4);

        // Jump from 0x10 to 0x400
        cyc(1'b1, 32'h1111_0010, 1'b0, 1'b0, 1'b1, 32'h0);
        chk("t2_pc_out_0x10", pc_out, 32'h10);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h400);
        chk("t2_addr_jump", imem_addr, 32'h400);
        w = 32'hCAFE_0400;
        cyc(1'b1, w, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t2_pc_out_jump", pc_out, 32'h400);
        chk("t2_instr_jump", instr_out, w);

        // Decode back-pressure
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, $urandom, 1'b0, 1'b0, 1'b0, $urandom);
            chk("t3_instr_hold", instr_out, w);
            chk("t3_pc_hold", pc_out, 32'h400);
            chk("t3_req_low", 32'(imem_req), 32'h0);
        end
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h20);

        // Flush while request for 0x20 is pending
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h100);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h100);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h100);
        cyc(1'b1, 32'hBAD0_0020, 1'b0, 1'b0, 1'b1, 32'h100);
        chk("t4_dropped_not_valid", 32'(instr_valid), 32'h0);
        chk("t4_redirect_addr", imem_addr, 32'h100);
        cyc(1'b1, 32'h600D_0100, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t4_pc_out", pc_out, 32'h100);
        chk("t4_instr", instr_out, 32'h600D_0100);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h200);

        // Timeout while ack is withheld
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEAD_0000);
            chk("t5_fetch_err", 32'(last_ferr), 32'(i == TIMEOUT - 1));
            chk("t5_addr_stable", imem_addr, 32'h200);
            chk("t5_req_high", 32'(imem_req), 32'h1);
        end
        cyc(1'b1, 32'h7777_0200, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t5_late_pc_out", pc_out, 32'h200);
        chk("t5_late_instr", instr_out, 32'h7777_0200);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h203);

        // Misaligned target
`ifdef FETCH_ALIGN_CHECK_EN
        exp_addr = 32'h200;
`else
        exp_addr = 32'h203;
`endif
        chk("t6_addr", imem_addr, exp_addr);
        chk("t6_align_err", 32'(align_err), 32'(exp_addr == 32'h200));
        cyc(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h300);
        chk("t6_align_sticky", 32'(align_err), 32'(exp_addr == 32'h200));

        // Random traffic, with periodic windows of a slow memory to provoke timeouts
        for (int i = 0; i < 3000; i++) begin
            ack_pct = ((i % 500) < 120) ? 3 : 45;
            ack = ($urandom_range(0, 99) < ack_pct);
            fl  = ($urandom_range(0, 9) == 0);
            st  = ($urandom_range(0, 3) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            np  = $urandom;
            if ($urandom_range(0, 15) != 0) np[1:0] = 2'b00;
            cyc(ack, $urandom, fl, st, rdy, np);
        end

        do_reset();
        cyc(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 32'h4);
        cyc(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 32'h4);
        chk("post_rst_pc_out", pc_out, 32'h0);
        chk("post_rst_instr", instr_out, 32'h1234_5678);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
